// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : Buffers issued B-type branches, resolves one per cycle through
//               the shared comparator, and reports outcome/redirect/squash.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_op1,
    input  logic [31:0]              in_op2,
    input  logic [2:0]               in_funct3,
    input  logic [31:0]              in_imm,
    input  logic                     in_pred_taken,
    input  logic [31:0]              in_pred_target,

    output logic [31:0]              cmp_op1,
    output logic [31:0]              cmp_op2,
    output logic [2:0]               cmp_type,
    input  logic                     cmp_result,

    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_pc,
    output logic [31:0]              res_target,
    output logic [31:0]              res_redirect_pc,
    output logic                     res_taken,
    output logic                     res_mispredict,
    output logic                     res_illegal,

    output logic                     squash,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         stat_resolved,
    output logic [CNT_W-1:0]         stat_mispredict
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                OCC_W      = PTR_W + 1;
    localparam logic [OCC_W-1:0]  c_OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0]  c_PTR_LAST = PTR_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Queue storage (payload only; validity is tracked by the occupancy)
    // ------------------------------------------------------------------
    logic [31:0] r_mem_pc          [DEPTH];
    logic [31:0] r_mem_op1         [DEPTH];
    logic [31:0] r_mem_op2         [DEPTH];
    logic [2:0]  r_mem_funct3      [DEPTH];
    logic [31:0] r_mem_imm         [DEPTH];
    logic        r_mem_pred_taken  [DEPTH];
    logic [31:0] r_mem_pred_target [DEPTH];

    logic [PTR_W-1:0] r_head_q, w_head_d;
    logic [PTR_W-1:0] r_tail_q, w_tail_d;
    logic [OCC_W-1:0] r_occ_q,  w_occ_d;

    logic        r_res_valid_q,      w_res_valid_d;
    logic [31:0] r_res_pc_q,         w_res_pc_d;
    logic [31:0] r_res_target_q,     w_res_target_d;
    logic [31:0] r_res_redirect_q,   w_res_redirect_d;
    logic        r_res_taken_q,      w_res_taken_d;
    logic        r_res_mispredict_q, w_res_mispredict_d;
    logic        r_res_illegal_q,    w_res_illegal_d;

    logic             r_squash_q,    w_squash_d;
    logic [CNT_W-1:0] r_stat_res_q,  w_stat_res_d;
    logic [CNT_W-1:0] r_stat_misp_q, w_stat_misp_d;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_accept;
    logic        w_squash_cond;

    logic [31:0] w_head_pc;
    logic [2:0]  w_head_funct3;
    logic [31:0] w_head_imm;
    logic        w_head_pred_taken;
    logic [31:0] w_head_pred_target;

    logic        w_illegal;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_redirect;
    logic        w_mispredict;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    assign w_empty       = (r_occ_q == '0);
    assign w_full        = (r_occ_q == c_OCC_FULL);
    assign w_accept      = r_res_valid_q && res_ready;
    assign w_squash_cond = w_accept && r_res_mispredict_q;

    // A full queue never accepts, even when the head is popping this cycle.
    assign in_ready = !w_full && !w_squash_cond;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && (!r_res_valid_q || res_ready) && !w_squash_cond;

    // ------------------------------------------------------------------
    // Head entry and resolution datapath
    // ------------------------------------------------------------------
    assign w_head_pc          = r_mem_pc[r_head_q];
    assign w_head_funct3      = r_mem_funct3[r_head_q];
    assign w_head_imm         = r_mem_imm[r_head_q];
    assign w_head_pred_taken  = r_mem_pred_taken[r_head_q];
    assign w_head_pred_target = r_mem_pred_target[r_head_q];

    assign cmp_op1  = w_empty ? 32'd0 : r_mem_op1[r_head_q];
    assign cmp_op2  = w_empty ? 32'd0 : r_mem_op2[r_head_q];
    assign cmp_type = w_empty ? 3'd0  : w_head_funct3;

    // funct3 010/011 are not defined for B-type; such branches never take.
    assign w_illegal    = (w_head_funct3[2:1] == 2'b01);
    assign w_taken      = cmp_result && !w_illegal;
    assign w_target     = w_head_pc + w_head_imm;
    assign w_redirect   = w_taken ? w_target : (w_head_pc + 32'd4);
    assign w_mispredict = (w_taken != w_head_pred_taken) ||
                          (w_taken && (w_head_pred_target != w_target));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_head_d = r_head_q;
        w_tail_d = r_tail_q;
        w_occ_d  = r_occ_q;
        if (w_squash_cond) begin
            w_head_d = '0;
            w_tail_d = '0;
            w_occ_d  = '0;
        end else begin
            if (w_pop) begin
                w_head_d = ptr_inc(r_head_q);
            end
            if (w_push) begin
                w_tail_d = ptr_inc(r_tail_q);
            end
            w_occ_d = r_occ_q + OCC_W'(w_push) - OCC_W'(w_pop);
        end
    end

    always_comb begin
        w_res_valid_d      = r_res_valid_q;
        w_res_pc_d         = r_res_pc_q;
        w_res_target_d     = r_res_target_q;
        w_res_redirect_d   = r_res_redirect_q;
        w_res_taken_d      = r_res_taken_q;
        w_res_mispredict_d = r_res_mispredict_q;
        w_res_illegal_d    = r_res_illegal_q;
        if (w_pop) begin
            w_res_valid_d      = 1'b1;
            w_res_pc_d         = w_head_pc;
            w_res_target_d     = w_target;
            w_res_redirect_d   = w_redirect;
            w_res_taken_d      = w_taken;
            w_res_mispredict_d = w_mispredict;
            w_res_illegal_d    = w_illegal;
        end else if (w_accept) begin
            w_res_valid_d = 1'b0;
        end
    end

    always_comb begin
        w_squash_d    = w_squash_cond;
        w_stat_res_d  = r_stat_res_q;
        w_stat_misp_d = r_stat_misp_q;
        if (w_accept) begin
            w_stat_res_d = r_stat_res_q + 1'b1;
        end
        if (w_squash_cond) begin
            w_stat_misp_d = r_stat_misp_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head_q           <= '0;
            r_tail_q           <= '0;
            r_occ_q            <= '0;
            r_res_valid_q      <= 1'b0;
            r_res_pc_q         <= '0;
            r_res_target_q     <= '0;
            r_res_redirect_q   <= '0;
            r_res_taken_q      <= 1'b0;
            r_res_mispredict_q <= 1'b0;
            r_res_illegal_q    <= 1'b0;
            r_squash_q         <= 1'b0;
            r_stat_res_q       <= '0;
            r_stat_misp_q      <= '0;
        end else begin
            r_head_q           <= w_head_d;
            r_tail_q           <= w_tail_d;
            r_occ_q            <= w_occ_d;
            r_res_valid_q      <= w_res_valid_d;
            r_res_pc_q         <= w_res_pc_d;
            r_res_target_q     <= w_res_target_d;
            r_res_redirect_q   <= w_res_redirect_d;
            r_res_taken_q      <= w_res_taken_d;
            r_res_mispredict_q <= w_res_mispredict_d;
            r_res_illegal_q    <= w_res_illegal_d;
            r_squash_q         <= w_squash_d;
            r_stat_res_q       <= w_stat_res_d;
            r_stat_misp_q      <= w_stat_misp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_pc[r_tail_q]          <= in_pc;
            r_mem_op1[r_tail_q]         <= in_op1;
            r_mem_op2[r_tail_q]         <= in_op2;
            r_mem_funct3[r_tail_q]      <= in_funct3;
            r_mem_imm[r_tail_q]         <= in_imm;
            r_mem_pred_taken[r_tail_q]  <= in_pred_taken;
            r_mem_pred_target[r_tail_q] <= in_pred_target;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign res_valid       = r_res_valid_q;
    assign res_pc          = r_res_pc_q;
    assign res_target      = r_res_target_q;
    assign res_redirect_pc = r_res_redirect_q;
    assign res_taken       = r_res_taken_q;
    assign res_mispredict  = r_res_mispredict_q;
    assign res_illegal     = r_res_illegal_q;
    assign squash          = r_squash_q;
    assign occupancy       = r_occ_q;
    assign stat_resolved   = r_stat_res_q;
    assign stat_mispredict = r_stat_misp_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_ctrl
// Description : Directed self-checking bench for branch_resolve_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_op1, in_op2, in_imm, in_pred_target;
    logic [2:0]  in_funct3;
    logic        in_pred_taken;
    logic [31:0] cmp_op1, cmp_op2;
    logic [2:0]  cmp_type;
    logic        cmp_result;
    logic        res_valid, res_ready;
    logic [31:0] res_pc, res_target, res_redirect_pc;
    logic        res_taken, res_mispredict, res_illegal;
    logic        squash;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0] stat_resolved, stat_mispredict;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_op1         (in_op1),
        .in_op2         (in_op2),
        .in_funct3      (in_funct3),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .cmp_op1        (cmp_op1),
        .cmp_op2        (cmp_op2),
        .cmp_type       (cmp_type),
        .cmp_result     (cmp_result),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_pc         (res_pc),
        .res_target     (res_target),
        .res_redirect_pc(res_redirect_pc),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .res_illegal    (res_illegal),
        .squash         (squash),
        .occupancy      (occupancy),
        .stat_resolved  (stat_resolved),
        .stat_mispredict(stat_mispredict)
    );

    always #5 clk = ~clk;

    // External comparator; undefined encodings report "met" so the
    // controller's own illegal-branch masking is exercised.
    always_comb begin
        cmp_result = 1'b0;
        case (cmp_type)
            3'b000:  cmp_result = (cmp_op1 == cmp_op2);
            3'b001:  cmp_result = (cmp_op1 != cmp_op2);
            3'b100:  cmp_result = ($signed(cmp_op1) <  $signed(cmp_op2));
            3'b101:  cmp_result = ($signed(cmp_op1) >= $signed(cmp_op2));
            3'b110:  cmp_result = (cmp_op1 <  cmp_op2);
            3'b111:  cmp_result = (cmp_op1 >= cmp_op2);
            default: cmp_result = 1'b1;
        endcase
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [2:0] f3,
                         input logic [31:0] imm, input logic pt,
                         input logic [31:0] ptgt);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_op1         = op1;
        in_op2         = op2;
        in_funct3      = f3;
        in_imm         = imm;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; res_ready = 1'b0;
        in_pc = '0; in_op1 = '0; in_op2 = '0; in_funct3 = '0;
        in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check_value("rst_occ",      32'(occupancy),       32'd0);
        check_value("rst_valid",    32'(res_valid),       32'd0);
        check_value("rst_squash",   32'(squash),          32'd0);
        check_value("rst_stat_res", 32'(stat_resolved),   32'd0);
        check_value("rst_stat_mis", 32'(stat_mispredict), 32'd0);
        check_value("rst_cmp_op1",  cmp_op1,              32'd0);
        check_value("rst_res_pc",   res_pc,               32'd0);
        check_value("rst_in_ready", 32'(in_ready),        32'd1);

        // BEQ taken, correctly predicted
        res_ready = 1'b1;
        offer(32'h100, 32'd5, 32'd5, 3'b000, 32'h20, 1'b1, 32'h120);
        step();
        in_valid = 1'b0;
        check_value("beq_occ1",     32'(occupancy), 32'd1);
        check_value("beq_nvalid",   32'(res_valid), 32'd0);
        check_value("beq_cmp_op1",  cmp_op1,        32'd5);
        step();
        check_value("beq_valid",    32'(res_valid),      32'd1);
        check_value("beq_pc",       res_pc,              32'h100);
        check_value("beq_taken",    32'(res_taken),      32'd1);
        check_value("beq_target",   res_target,          32'h120);
        check_value("beq_redirect", res_redirect_pc,     32'h120);
        check_value("beq_misp",     32'(res_mispredict), 32'd0);
        check_value("beq_illegal",  32'(res_illegal),    32'd0);
        check_value("beq_occ0",     32'(occupancy),      32'd0);
        step();
        check_value("beq_stat_res", 32'(stat_resolved), 32'd1);
        check_value("beq_drained",  32'(res_valid),     32'd0);

        // BLT signed: -1 < 1 taken, predicted not-taken
        offer(32'h200, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'h40, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        check_value("blt_taken",    32'(res_taken),      32'd1);
        check_value("blt_target",   res_target,          32'h240);
        check_value("blt_redirect", res_redirect_pc,     32'h240);
        check_value("blt_misp",     32'(res_mispredict), 32'd1);
        step();
        check_value("blt_squash",   32'(squash),          32'd1);
        check_value("blt_stat_mis", 32'(stat_mispredict), 32'd1);
        check_value("blt_valid0",   32'(res_valid),       32'd0);
        step();
        check_value("blt_squash_end", 32'(squash), 32'd0);

        // BLTU same operands: 0xFFFFFFFF < 1 is false
        offer(32'h300, 32'hFFFF_FFFF, 32'd1, 3'b110, 32'h40, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        check_value("bltu_taken",    32'(res_taken),      32'd0);
        check_value("bltu_redirect", res_redirect_pc,     32'h304);
        check_value("bltu_misp",     32'(res_mispredict), 32'd0);
        step();
        check_value("bltu_stat_res", 32'(stat_resolved), 32'd3);

        // Fill: one record held in the result register plus four queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(32'h1000 + 32'(4 * i), 32'd7, 32'd7, 3'b000, 32'd8, 1'b1,
                  32'h1008 + 32'(4 * i));
            step();
        end
        check_value("full_occ",   32'(occupancy), 32'd4);
        check_value("full_ready", 32'(in_ready),  32'd0);
        check_value("full_head",  res_pc,         32'h1000);
        offer(32'h2000, 32'd7, 32'd7, 3'b000, 32'd8, 1'b1, 32'h2008);
        step();
        step();
        check_value("held_occ",   32'(occupancy), 32'd4);
        check_value("held_ready", 32'(in_ready),  32'd0);
        check_value("hold_pc",    res_pc,         32'h1000);
        check_value("hold_tgt",   res_target,     32'h1008);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_value("drain_valid", 32'(res_valid), 32'd1);
            check_value("drain_pc",    res_pc,         32'h1000 + 32'(4 * i));
            check_value("drain_tgt",   res_target,     32'h1008 + 32'(4 * i));
            step();
        end
        check_value("drain_empty",    32'(res_valid),     32'd0);
        check_value("drain_occ",      32'(occupancy),     32'd0);
        check_value("drain_stat_res", 32'(stat_resolved), 32'd8);

        // Mispredict squash with a concurrent offer
        res_ready = 1'b0;
        offer(32'h3000, 32'd9, 32'd9, 3'b001, 32'h10, 1'b1, 32'h3010);
        step();
        offer(32'h3004, 32'd1, 32'd1, 3'b000, 32'd4, 1'b1, 32'h3008);
        step();
        offer(32'h3008, 32'd1, 32'd1, 3'b000, 32'd4, 1'b1, 32'h300C);
        step();
        check_value("sq_occ_pre", 32'(occupancy),      32'd2);
        check_value("sq_head_pc", res_pc,              32'h3000);
        check_value("sq_misp",    32'(res_mispredict), 32'd1);
        offer(32'h4000, 32'd2, 32'd2, 3'b000, 32'h10, 1'b1, 32'h4010);
        res_ready = 1'b1;
        #1;
        check_value("sq_refuse", 32'(in_ready), 32'd0);
        step();
        check_value("sq_pulse",    32'(squash),          32'd1);
        check_value("sq_occ",      32'(occupancy),       32'd0);
        check_value("sq_valid",    32'(res_valid),       32'd0);
        check_value("sq_stat_mis", 32'(stat_mispredict), 32'd2);
        check_value("sq_ready",    32'(in_ready),        32'd1);
        step();
        in_valid = 1'b0;
        check_value("sq_pulse_end", 32'(squash),    32'd0);
        check_value("sq_post_occ",  32'(occupancy), 32'd1);
        check_value("sq_post_nv",   32'(res_valid), 32'd0);
        step();
        check_value("sq_post_valid", 32'(res_valid),      32'd1);
        check_value("sq_post_pc",    res_pc,              32'h4000);
        check_value("sq_post_misp",  32'(res_mispredict), 32'd0);
        step();
        check_value("sq_stat_res", 32'(stat_resolved),   32'd10);
        check_value("sq_stat_mis2", 32'(stat_mispredict), 32'd2);

        // Illegal funct3 010
        offer(32'h500, 32'd3, 32'd4, 3'b010, 32'h10, 1'b1, 32'h510);
        step();
        in_valid = 1'b0;
        step();
        check_value("ill_flag",     32'(res_illegal),    32'd1);
        check_value("ill_taken",    32'(res_taken),      32'd0);
        check_value("ill_misp",     32'(res_mispredict), 32'd1);
        check_value("ill_redirect", res_redirect_pc,     32'h504);
        step();
        check_value("ill_squash",   32'(squash),          32'd1);
        check_value("ill_stat_mis", 32'(stat_mispredict), 32'd3);
        check_value("ill_stat_res", 32'(stat_resolved),   32'd11);

        // Reset mid-operation
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h600 + 32'(4 * i), 32'd1, 32'd1, 3'b000, 32'd8, 1'b1,
                  32'h608 + 32'(4 * i));
            step();
        end
        in_valid = 1'b0;
        check_value("mr_occ_pre",   32'(occupancy), 32'd2);
        check_value("mr_valid_pre", 32'(res_valid), 32'd1);
        reset = 1'b1;
        step();
        check_value("mr_occ",      32'(occupancy),       32'd0);
        check_value("mr_valid",    32'(res_valid),       32'd0);
        check_value("mr_stat_res", 32'(stat_resolved),   32'd0);
        check_value("mr_stat_mis", 32'(stat_mispredict), 32'd0);
        check_value("mr_ready",    32'(in_ready),        32'd1);
        check_value("mr_cmp_op1",  cmp_op1,              32'd0);
        reset     = 1'b0;
        res_ready = 1'b1;
        step();
        check_value("mr_no_res",   32'(res_valid),     32'd0);
        check_value("mr_no_stat",  32'(stat_resolved), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
